// File: rtl/vector_sweep_controller.sv
// Exhaustive stimulus sequencer: resets a benchmark DUT, walks every input pattern,
// hands each (vector, response) record to a logger and folds responses into a MISR.
module vector_sweep_controller #(
    parameter int              N_IN   = 3,
    parameter int              N_OUT  = 1,
    parameter int              SETTLE = 1,
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   dut_in,
    output logic              dut_reset,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [N_IN-1:0]   sample_vec,
    output logic [N_OUT-1:0]  sample_resp,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [N_IN:0]     vec_count
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE);
    localparam logic [CW-1:0]   CNT_ONE   = 1;
    localparam logic [N_IN-1:0] VEC_ONE   = 1;
    localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};
    localparam logic [N_IN:0]   COUNT_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUT_RST,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN-1:0]   samp_vec_q, samp_vec_d;
    logic [N_OUT-1:0]  samp_resp_q, samp_resp_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [N_IN:0]     count_q, count_d;
    logic [SIG_W-1:0]  sig_step;

    assign sig_step = (sig_q << 1)
                    ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                    ^ SIG_W'(samp_resp_q);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        dut_in_d    = dut_in_q;
        cnt_d       = cnt_q;
        samp_vec_d  = samp_vec_q;
        samp_resp_d = samp_resp_q;
        sig_d       = sig_q;
        count_d     = count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_DUT_RST;
                    vec_d    = '0;
                    dut_in_d = '0;
                    sig_d    = '0;
                    count_d  = '0;
                end
            end
            S_DUT_RST: begin
                state_d  = S_APPLY;
                dut_in_d = vec_q;
            end
            S_APPLY: begin
                cnt_d = SETTLE_LD;
                if (SETTLE > 0) begin
                    state_d = S_SETTLE;
                end else begin
                    state_d     = S_CAPTURE;
                    samp_vec_d  = vec_q;
                    samp_resp_d = dut_out;
                end
            end
            S_SETTLE: begin
                // Sample on the edge that leaves the last settle cycle.
                if (cnt_q <= CNT_ONE) begin
                    state_d     = S_CAPTURE;
                    samp_vec_d  = vec_q;
                    samp_resp_d = dut_out;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_CAPTURE: begin
                if (sample_ready) begin
                    sig_d   = sig_step;
                    count_d = count_q + COUNT_ONE;
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_APPLY;
                        vec_d    = vec_q + VEC_ONE;
                        dut_in_d = vec_q + VEC_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats any same-cycle handshake or restart: nothing accumulates.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            dut_in_d    = '0;
            vec_d       = vec_q;
            cnt_d       = cnt_q;
            samp_vec_d  = samp_vec_q;
            samp_resp_d = samp_resp_q;
            sig_d       = sig_q;
            count_d     = count_q;
        end
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            dut_in_q    <= '0;
            cnt_q       <= '0;
            samp_vec_q  <= '0;
            samp_resp_q <= '0;
            sig_q       <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            dut_in_q    <= dut_in_d;
            cnt_q       <= cnt_d;
            samp_vec_q  <= samp_vec_d;
            samp_resp_q <= samp_resp_d;
            sig_q       <= sig_d;
            count_q     <= count_d;
        end
    end

    assign dut_in       = dut_in_q;
    assign dut_reset    = (state_q == S_DUT_RST);
    assign sample_valid = (state_q == S_CAPTURE);
    assign sample_vec   = samp_vec_q;
    assign sample_resp  = samp_resp_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign signature    = sig_q;
    assign vec_count    = count_q;

endmodule

// File: doc/vector_sweep_controller.md
Name: vector_sweep_controller

Overview:
- Sequences an exhaustive stimulus sweep over a small combinational/sequential benchmark DUT used in trojan-detection characterisation.
- Pulses DUT reset, applies every input pattern 0..2^N_IN-1 in ascending order and waits a programmable settle time.
- Captures the DUT response, hands each (vector, response) pair to a downstream logger over a valid/ready handshake, and folds the responses into a MISR signature.
- Replaces the free-running bench sweep with a synthesizable, backpressure-aware sequencer.

Parameters:
- N_IN, 3, DUT input width; sweep length = 2^N_IN vectors.
- N_OUT, 1, DUT output width (N_OUT <= SIG_W).
- SETTLE, 1, cycles between applying a vector and sampling dut_out; 0 is legal.
- SIG_W, 16, signature width.
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).

Ports:
- CK  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin sweep; accepted in IDLE or DONE only
- abort  in  1  cancel sweep; effective in any non-IDLE state
- dut_in  out  N_IN  vector driven to DUT; binary value = vector index, bit 0 = LSB
- dut_reset  out  1  reset pulse to DUT
- dut_out  in  N_OUT  DUT response
- sample_valid  out  1  capture record valid
- sample_ready  in  1  logger accepts record
- sample_vec  out  N_IN  vector of current record
- sample_resp  out  N_OUT  response of current record
- busy  out  1  sweep in progress
- done  out  1  sweep completed, held until next start/abort/reset
- signature  out  SIG_W  MISR result
- vec_count  out  N_IN+1  records accepted so far

Behaviour:
- Reset: state=IDLE; every output 0 (dut_in, dut_reset, sample_*, busy, done, signature, vec_count). Reset overrides start and abort in the same cycle.
- States: IDLE, DUT_RST, APPLY, SETTLE, CAPTURE, DONE.
- IDLE: busy=0. start -> DUT_RST.
- DUT_RST: exactly one cycle. Drives dut_reset=1, busy=1, done=0, vec=0, signature=0, vec_count=0. -> APPLY.
- APPLY: one cycle. dut_in=vec; settle counter loaded with SETTLE. -> SETTLE if SETTLE>0, else CAPTURE.
- SETTLE: counter decrements each cycle; -> CAPTURE when it reaches 1.
- Sampling point: dut_out and vec are registered into sample_resp/sample_vec on the edge that enters CAPTURE. sample_valid=1 from that cycle.
- CAPTURE: sample_valid, sample_vec and sample_resp held stable until sample_ready=1. On handshake (valid & ready):
  - signature <= (signature<<1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zero_ext(sample_resp)
  - vec_count += 1
  - sample_valid deasserts next cycle
  - if vec == 2^N_IN-1 -> DONE; else vec += 1 -> APPLY
- dut_in holds the current vector from APPLY through CAPTURE.
- DONE: busy=0, done=1; signature and vec_count frozen. start -> DUT_RST (new sweep).
- Per-vector latency with ready tied high: 2+SETTLE cycles. Full sweep: 1 + 2^N_IN*(2+SETTLE) cycles from start-accept to entering DONE.
- start while busy: ignored.
- abort (non-IDLE): next state IDLE; sample_valid, busy and done drop; dut_in=0; signature and vec_count retain last values. abort wins over a same-cycle handshake, so that record is not counted. abort in IDLE is a no-op.
- Vector wrap: never increments past 2^N_IN-1; vec_count reaches 2^N_IN exactly.

Test Plan:
- Defaults; DUT model dut_out=dut_in[0]; ready=1; pulse start -> records (0,0),(1,1)...(7,1) in order; signature=16'h0055; vec_count=8; done at cycle 25 after start-accept.
- DUT model dut_out=1 constant -> signature=16'h00FF, vec_count=8.
- Same as the first scenario, but sample_ready held low for 5 cycles on vector 3 -> sample_vec/sample_resp stable throughout the stall, no duplicate or lost record, final signature=16'h0055, done 5 cycles later.
- abort asserted during CAPTURE of vector 4 with ready=1 in the same cycle -> IDLE next cycle, vec_count=4, busy=0, done=0; subsequent start gives a full sweep with signature=16'h0055.
- SETTLE=0 and SETTLE=3 sweeps -> completion at 17 and 41 cycles respectively; DUT with 2-cycle output delay and SETTLE=3 yields correct records.
- reset asserted mid-sweep, simultaneous with start -> all outputs 0, state IDLE; start while busy has no effect (vec_count unaffected).
